// File: rtl/instr_mem_loader_if.sv
// Byte-stream, BRAM write-port and core-control signals of the boot-time
// instruction memory loader. The loader drives the master side.
interface instr_mem_loader_if #(
    parameter int ADDR_WIDTH = 15
);
    logic                  rx_valid;
    logic [7:0]            rx_data;
    logic                  tx_valid;
    logic [7:0]            tx_data;
    logic                  tx_ready;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [31:0]           wr_data;
    logic                  core_reset;
    logic                  loaded;

    modport master (
        input  rx_valid, rx_data, tx_ready,
        output tx_valid, tx_data, wr_en, wr_addr, wr_data, core_reset, loaded
    );

    modport slave (
        output rx_valid, rx_data, tx_ready,
        input  tx_valid, tx_data, wr_en, wr_addr, wr_data, core_reset, loaded
    );
endinterface

// File: rtl/instr_mem_loader.sv
// Boot loader: assembles little-endian words from the RX byte stream into instruction
// memory, answers ACK/NAK on TX and then releases the core. Optional LOADER_CHECKSUM_EN.
module instr_mem_loader #(
    parameter int         ADDR_WIDTH = 15,
    parameter logic [7:0] ACK_BYTE   = 8'hAA,
    parameter logic [7:0] NAK_BYTE   = 8'h55
) (
    input  logic                clock,
    input  logic                reset,
    instr_mem_loader_if.master  bus
);
    typedef enum logic [2:0] {
        ST_HEADER = 3'd0,
        ST_DATA   = 3'd1,
        ST_CHECK  = 3'd2,
        ST_ACK    = 3'd3,
        ST_NAK    = 3'd4,
        ST_RUN    = 3'd5
    } state_e;

    localparam logic [31:0]         N_MAX   = 32'd1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0] CNT_ZERO = {(ADDR_WIDTH+1){1'b0}};

    state_e                state_q, state_d;
    logic [1:0]            byte_cnt_q, byte_cnt_d;
    logic [ADDR_WIDTH:0]   word_cnt_q, word_cnt_d;
    logic [ADDR_WIDTH:0]   n_q, n_d;
    logic [23:0]           word_q, word_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]           wr_data_q, wr_data_d;
    logic                  tx_valid_q, tx_valid_d;
    logic [7:0]            tx_data_q, tx_data_d;
    logic                  core_reset_q, core_reset_d;
    logic                  loaded_q, loaded_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]            csum_q, csum_d;
`endif

    logic [31:0] word_full_s;
    logic        byte_last_s;
    logic        tx_hs_s;

    // Earlier bytes sit in word_q[23:0]; the current byte is the top of the word.
    assign word_full_s = {bus.rx_data, word_q};
    assign byte_last_s = bus.rx_valid && (byte_cnt_q == 2'd3);
    assign tx_hs_s     = tx_valid_q && bus.tx_ready;

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= ST_HEADER;
            byte_cnt_q   <= 2'd0;
            word_cnt_q   <= CNT_ZERO;
            n_q          <= CNT_ZERO;
            word_q       <= 24'd0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= {ADDR_WIDTH{1'b0}};
            wr_data_q    <= 32'd0;
            tx_valid_q   <= 1'b0;
            tx_data_q    <= 8'd0;
            core_reset_q <= 1'b1;
            loaded_q     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_q       <= 8'd0;
`endif
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            word_cnt_q   <= word_cnt_d;
            n_q          <= n_d;
            word_q       <= word_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            tx_valid_q   <= tx_valid_d;
            tx_data_q    <= tx_data_d;
            core_reset_q <= core_reset_d;
            loaded_q     <= loaded_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q       <= csum_d;
`endif
        end
    end

    // Next-state logic: byte assembly, header decode, word counting, handshakes.
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        word_cnt_d = word_cnt_q;
        n_d        = n_q;
        word_d     = word_q;
`ifdef LOADER_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        case (state_q)
            ST_HEADER: begin
                if (bus.rx_valid) begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    word_d     = {bus.rx_data, word_q[23:8]};
                    if (byte_last_s) begin
                        word_cnt_d = CNT_ZERO;
                        n_d        = word_full_s[ADDR_WIDTH:0];
`ifdef LOADER_CHECKSUM_EN
                        csum_d     = 8'd0;
`endif
                        if (word_full_s == 32'd0) begin
`ifdef LOADER_CHECKSUM_EN
                            state_d = ST_CHECK;
`else
                            state_d = ST_ACK;
`endif
                        end else if (word_full_s > N_MAX) begin
                            state_d = ST_NAK;
                        end else begin
                            state_d = ST_DATA;
                        end
                    end else begin
                        state_d = ST_HEADER;
                    end
                end else begin
                    state_d = ST_HEADER;
                end
            end
            ST_DATA: begin
                if (bus.rx_valid) begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    word_d     = {bus.rx_data, word_q[23:8]};
`ifdef LOADER_CHECKSUM_EN
                    csum_d     = csum_q ^ bus.rx_data;
`endif
                    if (byte_last_s) begin
                        word_cnt_d = word_cnt_q + CNT_ONE;
                        if ((word_cnt_q + CNT_ONE) == n_q) begin
`ifdef LOADER_CHECKSUM_EN
                            state_d = ST_CHECK;
`else
                            state_d = ST_ACK;
`endif
                        end else begin
                            state_d = ST_DATA;
                        end
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_CHECK: begin
`ifdef LOADER_CHECKSUM_EN
                if (bus.rx_valid) begin
                    state_d = (bus.rx_data == csum_q) ? ST_ACK : ST_NAK;
                end else begin
                    state_d = ST_CHECK;
                end
`else
                state_d = ST_HEADER;
`endif
            end
            ST_ACK: begin
                if (tx_hs_s) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_ACK;
                end
            end
            ST_NAK: begin
                if (tx_hs_s) begin
                    state_d    = ST_HEADER;
                    byte_cnt_d = 2'd0;
                    word_cnt_d = CNT_ZERO;
                end else begin
                    state_d = ST_NAK;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_HEADER;
            end
        endcase
    end

    // Output logic, registered: outputs follow the state being entered.
    always_comb begin
        wr_en_d      = (state_q == ST_DATA) && byte_last_s;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        if (wr_en_d) begin
            wr_addr_d = word_cnt_q[ADDR_WIDTH-1:0];
            wr_data_d = word_full_s;
        end else begin
            wr_addr_d = wr_addr_q;
            wr_data_d = wr_data_q;
        end
        tx_valid_d   = (state_d == ST_ACK) || (state_d == ST_NAK);
        tx_data_d    = (state_d == ST_NAK) ? NAK_BYTE : ACK_BYTE;
        core_reset_d = (state_d != ST_RUN);
        loaded_d     = (state_d == ST_RUN);
    end

    assign bus.wr_en      = wr_en_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.tx_valid   = tx_valid_q;
    assign bus.tx_data    = tx_data_q;
    assign bus.core_reset = core_reset_q;
    assign bus.loaded     = loaded_q;
endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader: expected writes and TX bytes are queued as
// stimulus is driven and checked by a negedge monitor.
module tb_instr_mem_loader;
    localparam int AW = 15;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    instr_mem_loader_if #(.ADDR_WIDTH(AW)) bus_if ();

    instr_mem_loader #(.ADDR_WIDTH(AW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if.master)
    );

    int total = 0;
    int bad   = 0;
    logic [7:0]     exp_tx[$];
    logic [AW+31:0] exp_wr[$];
    logic           post_hs = 1'b0;
    logic           hs_ack  = 1'b0;
    logic [7:0]     csum    = 8'd0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    // Monitor: pop expected writes / TX bytes, check release timing after each handshake.
    always @(negedge clock) begin
        logic [AW+31:0] e;
        if (post_hs) begin
            chk("post_hs_core_reset", 64'(bus_if.core_reset), 64'(!hs_ack));
            chk("post_hs_loaded", 64'(bus_if.loaded), 64'(hs_ack));
            chk("post_hs_tx_valid", 64'(bus_if.tx_valid), 64'd0);
            post_hs = 1'b0;
        end
        if (bus_if.wr_en === 1'b1) begin
            if (exp_wr.size() == 0) begin
                chk("wr_unexpected", 64'd1, 64'd0);
            end else begin
                e = exp_wr.pop_front();
                chk("wr_addr", 64'(bus_if.wr_addr), 64'(e[AW+31:32]));
                chk("wr_data", 64'(bus_if.wr_data), 64'(e[31:0]));
            end
        end
        if (bus_if.tx_valid === 1'b1) begin
            if (exp_tx.size() == 0) begin
                chk("tx_unexpected", 64'd1, 64'd0);
            end else begin
                chk("tx_data", 64'(bus_if.tx_data), 64'(exp_tx[0]));
                chk("tx_core_reset", 64'(bus_if.core_reset), 64'd1);
                if (bus_if.tx_ready) begin
                    hs_ack  = (exp_tx[0] == 8'hAA);
                    void'(exp_tx.pop_front());
                    post_hs = 1'b1;
                end
            end
        end
    end

    // Called at posedge+1; returns at the next posedge+1 with rx_valid low.
    task automatic send_byte(input logic [7:0] b);
        bus_if.rx_valid = 1'b1;
        bus_if.rx_data  = b;
        @(posedge clock);
        #1;
        bus_if.rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send_header(input logic [31:0] n);
        csum = 8'd0;
        for (int k = 0; k < 4; k++) send_byte(n[8*k +: 8]);
    endtask

    task automatic send_word(input logic [31:0] w, input logic [AW-1:0] addr);
        exp_wr.push_back({addr, w});
        for (int k = 0; k < 4; k++) begin
            send_byte(w[8*k +: 8]);
            csum = csum ^ w[8*k +: 8];
        end
        chk("wr_latency", 64'(bus_if.wr_en), 64'd1);
    endtask

    task automatic send_check();
`ifdef LOADER_CHECKSUM_EN
        send_byte(csum);
`endif
    endtask

    task automatic wait_tx();
        int cyc = 0;
        while (exp_tx.size() != 0 && cyc < 200) begin
            @(negedge clock);
            cyc++;
        end
        chk("tx_timeout", 64'(exp_tx.size() == 0), 64'd1);
        @(negedge clock);
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        chk("sb_wr_empty", 64'(exp_wr.size()), 64'd0);
        reset = 1'b0;
        bus_if.rx_valid = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_wr_en", 64'(bus_if.wr_en), 64'd0);
        chk("rst_tx_valid", 64'(bus_if.tx_valid), 64'd0);
        chk("rst_core_reset", 64'(bus_if.core_reset), 64'd1);
        chk("rst_loaded", 64'(bus_if.loaded), 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        post_hs = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=running want=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus_if.rx_valid = 1'b0;
        bus_if.rx_data  = 8'd0;
        bus_if.tx_ready = 1'b1;
        apply_reset();

        // Two-word load; then bytes in RUN must be ignored.
        exp_tx.push_back(8'hAA);
        send_header(32'd2);
        send_word(32'hF000_0000, 15'd0);
        send_word(32'h1C00_01FD, 15'd1);
        send_check();
        wait_tx();
        chk("t1_loaded", 64'(bus_if.loaded), 64'd1);
        for (int k = 0; k < 4; k++) send_byte(8'h10 + 8'(k));
        idle(3);
        chk("run_loaded", 64'(bus_if.loaded), 64'd1);
        chk("run_core_reset", 64'(bus_if.core_reset), 64'd0);

        // Empty program.
        apply_reset();
        exp_tx.push_back(8'hAA);
        send_header(32'd0);
        send_check();
        wait_tx();
        chk("n0_loaded", 64'(bus_if.loaded), 64'd1);

        // Oversized header rejected, bytes ignored while NAK pending, then a good load.
        apply_reset();
        bus_if.tx_ready = 1'b0;
        exp_tx.push_back(8'h55);
        send_header(32'h0000_8001);
        send_byte(8'h01);
        send_byte(8'h02);
        idle(2);
        bus_if.tx_ready = 1'b1;
        wait_tx();
        chk("nak_core_reset", 64'(bus_if.core_reset), 64'd1);
        chk("nak_loaded", 64'(bus_if.loaded), 64'd0);
        exp_tx.push_back(8'hAA);
        send_header(32'd1);
        send_word(32'hDEAD_BEEF, 15'd0);
        send_check();
        wait_tx();
        chk("after_nak_loaded", 64'(bus_if.loaded), 64'd1);

        // Back-to-back bytes with TX stalled for 5 cycles.
        apply_reset();
        bus_if.tx_ready = 1'b0;
        exp_tx.push_back(8'hAA);
        send_header(32'd2);
        send_word(32'hA5A5_0001, 15'd0);
        send_word(32'h5A5A_FFFE, 15'd1);
        send_check();
        idle(5);
        chk("stall_core_reset", 64'(bus_if.core_reset), 64'd1);
        bus_if.tx_ready = 1'b1;
        wait_tx();
        chk("stall_loaded", 64'(bus_if.loaded), 64'd1);

        // Full-memory header is accepted (no NAK, first word written).
        apply_reset();
        send_header(32'h0000_8000);
        send_word(32'h0123_4567, 15'd0);
        idle(2);
        chk("nmax_tx_valid", 64'(bus_if.tx_valid), 64'd0);
        chk("nmax_core_reset", 64'(bus_if.core_reset), 64'd1);

        // Reset after 6 of 12 bytes, then a fresh load from address 0.
        apply_reset();
        send_header(32'd2);
        send_byte(8'h11);
        send_byte(8'h22);
        apply_reset();
        exp_tx.push_back(8'hAA);
        send_header(32'd2);
        send_word(32'hCAFE_0000, 15'd0);
        send_word(32'h0000_BABE, 15'd1);
        send_check();
        wait_tx();
        chk("fresh_loaded", 64'(bus_if.loaded), 64'd1);

`ifdef LOADER_CHECKSUM_EN
        apply_reset();
        exp_tx.push_back(8'hAA);
        send_header(32'd1);
        send_word(32'h1122_3344, 15'd0);
        send_byte(8'h44);
        wait_tx();
        chk("csum_ok_loaded", 64'(bus_if.loaded), 64'd1);
        apply_reset();
        exp_tx.push_back(8'h55);
        send_header(32'd1);
        send_word(32'h1122_3344, 15'd0);
        send_byte(8'h45);
        wait_tx();
        chk("csum_bad_core_reset", 64'(bus_if.core_reset), 64'd1);
        chk("csum_bad_loaded", 64'(bus_if.loaded), 64'd0);
`endif

        idle(2);
        chk("sb_wr_final", 64'(exp_wr.size()), 64'd0);
        chk("sb_tx_final", 64'(exp_tx.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
